bf_fetch: RTL and testbench



---
 rtl/bf_fetch.sv | 254 +++++++++++++++++++++++++
 tb/tb_bf_fetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_fetch.sv
// rtl/bf_fetch.sv - Brainfuck CPU program-sequencing (fetch) stage
//
// Purpose: drives the program ROM address, decodes the returned opcode,
// resolves [ / ] control flow internally with a depth-counted bracket scan,
// and hands data ops (+ - > < . ,) to the executor over valid/ready.
// End of program is taken from the ROM overrun flag.
//
// Optional feature macro: BF_RETURN_STACK_EN
//   defined   - a STACK_DEPTH x ADDR_W LIFO of [ addresses makes backward
//               jumps single-cycle (no SCAN_BACK traversal).
//   undefined - no stack storage; backward jumps scan one address per cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin execution at address 0 (honoured in IDLE or HALT)
//   rom_addr     program counter to the ROM
//   rom_code     opcode from the ROM (combinational from rom_addr)
//   rom_overrun  rom_addr is past the end of the program
//   op_valid     op_code carries a data op for the executor
//   op_code      the current opcode
//   op_ready     executor accepts the op this cycle
//   cell_zero    current data cell is zero
//   busy         running (RUN, SKIP_FWD or SCAN_BACK)
//   halted       execution finished
//   error        sticky fault flag
module bf_fetch #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_W     = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_code,
    input  logic              rom_overrun,
    output logic              op_valid,
    output logic [2:0]        op_code,
    input  logic              op_ready,
    input  logic              cell_zero,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SKIP_FWD,
        S_SCAN_BACK,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_OPEN  = 3'b011;
    localparam logic [2:0] OP_CLOSE = 3'b010;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                halted_q, halted_d;
    logic                error_q, error_d;
    logic                fault;

    logic is_open, is_close, is_data, depth_full, depth_one, pc_zero;

    assign is_open    = (rom_code == OP_OPEN);
    assign is_close   = (rom_code == OP_CLOSE);
    assign is_data    = !is_open && !is_close;
    assign depth_full = &depth_q;
    assign depth_one  = (depth_q == DEPTH_W'(1));
    assign pc_zero    = (pc_q == '0);

`ifdef BF_RETURN_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              push;
    logic              stack_full, stack_empty;
    logic [ADDR_W-1:0] stack_top;

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign stack_top   = stack_mem[IDX_W'(sp_q - SP_W'(1))];

    // Storage carries no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[IDX_W'(sp_q)] <= pc_q;
        end
    end
`else
    localparam int unused_stack_depth = STACK_DEPTH;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        halted_d = halted_q;
        error_d  = error_q;
        fault    = 1'b0;
`ifdef BF_RETURN_STACK_EN
        sp_d     = sp_q;
        push     = 1'b0;
`endif
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d  = S_RUN;
                    pc_d     = '0;
                    depth_d  = '0;
                    halted_d = 1'b0;
                    error_d  = 1'b0;
`ifdef BF_RETURN_STACK_EN
                    sp_d     = '0;
`endif
                end
            end
            S_RUN: begin
                if (rom_overrun) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (is_data) begin
                    if (op_ready) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end else if (is_open) begin
                    if (cell_zero) begin
                        depth_d = DEPTH_W'(1);
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_SKIP_FWD;
                    end else begin
`ifdef BF_RETURN_STACK_EN
                        if (stack_full) begin
                            fault = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                            pc_d = pc_q + ADDR_W'(1);
                        end
`else
                        pc_d = pc_q + ADDR_W'(1);
`endif
                    end
                end else begin
`ifdef BF_RETURN_STACK_EN
                    if (stack_empty) begin
                        fault = 1'b1;
                    end else if (cell_zero) begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = pc_q + ADDR_W'(1);
                    end else begin
                        // Loop back: land just past the matching [ and keep it stacked.
                        pc_d = stack_top + ADDR_W'(1);
                    end
`else
                    if (cell_zero) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end else if (pc_zero) begin
                        fault = 1'b1;
                    end else begin
                        depth_d = DEPTH_W'(1);
                        pc_d    = pc_q - ADDR_W'(1);
                        state_d = S_SCAN_BACK;
                    end
`endif
                end
            end
            S_SKIP_FWD: begin
                if (rom_overrun) begin
                    fault = 1'b1;
                end else if (is_open) begin
                    if (depth_full) begin
                        fault = 1'b1;
                    end else begin
                        depth_d = depth_q + DEPTH_W'(1);
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end else if (is_close) begin
                    depth_d = depth_q - DEPTH_W'(1);
                    pc_d    = pc_q + ADDR_W'(1);
                    if (depth_one) begin
                        state_d = S_RUN;
                    end
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            S_SCAN_BACK: begin
                if (is_close && depth_full) begin
                    fault = 1'b1;
                end else if (is_open && depth_one) begin
                    depth_d = '0;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_RUN;
                end else begin
                    if (is_close) begin
                        depth_d = depth_q + DEPTH_W'(1);
                    end else if (is_open) begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                    // Reaching address 0 with no match is an unmatched ].
                    if (pc_zero) begin
                        fault = 1'b1;
                    end else begin
                        pc_d = pc_q - ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fault) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            error_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            depth_q  <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef BF_RETURN_STACK_EN
            sp_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            halted_q <= halted_d;
            error_q  <= error_d;
`ifdef BF_RETURN_STACK_EN
            sp_q     <= sp_d;
`endif
        end
    end

    assign rom_addr = pc_q;
    assign op_code  = rom_code;
    assign op_valid = (state_q == S_RUN) && !rom_overrun && is_data;
    assign busy     = (state_q == S_RUN) || (state_q == S_SKIP_FWD) ||
                      (state_q == S_SCAN_BACK);
    assign halted   = halted_q;
    assign error    = error_q;

endmodule

// File: tb/tb_bf_fetch.sv
// tb/tb_bf_fetch.sv - self-checking bench for bf_fetch
module tb_bf_fetch;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] rom_addr;
    logic [2:0] rom_code;
    logic       rom_overrun;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic       cell_zero;
    logic       busy;
    logic       halted;
    logic       error;

    bf_fetch #(
        .ADDR_W     (8),
        .DEPTH_W    (2),
        .STACK_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_code   (rom_code),
        .rom_overrun(rom_overrun),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .cell_zero  (cell_zero),
        .busy       (busy),
        .halted     (halted),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program ROM model
    logic [2:0] rom [32];
    int         rom_len;

    always_comb begin
        rom_overrun = (int'(rom_addr) >= rom_len);
        rom_code    = rom_overrun ? 3'b000 : rom[rom_addr[4:0]];
    end

    task automatic load_prog(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     rom[i] = 3'b111;
                "-":     rom[i] = 3'b110;
                ">":     rom[i] = 3'b101;
                "<":     rom[i] = 3'b100;
                "[":     rom[i] = 3'b011;
                "]":     rom[i] = 3'b010;
                ".":     rom[i] = 3'b001;
                default: rom[i] = 3'b000;
            endcase
        end
        rom_len = s.len();
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string prog;
        bit    start;
        bit    rdy;
        bit    cz;
        int    addr;
        bit    vld;
        int    code;
        bit    bsy;
        bit    hlt;
        bit    err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string p, input bit st, input bit rdy, input bit cz,
                                input int addr, input bit vld, input int code,
                                input bit bsy, input bit hlt, input bit err);
        vec_t v;
        v.prog = p; v.start = st; v.rdy = rdy; v.cz = cz;
        v.addr = addr; v.vld = vld; v.code = code;
        v.bsy = bsy; v.hlt = hlt; v.err = err;
        tbl.push_back(v);
    endfunction

    int         minus_cnt;
    bit         done;
    logic [7:0] trace[$];
    logic [2:0] ops[$];
    int         exp_trace[$];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op_ready = 1'b0; cell_zero = 1'b0;
        load_prog("++.");

        // Reset values
        @(negedge clk); #1;
        chk("rst.addr", rom_addr, 0);
        chk("rst.valid", op_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.halted", halted, 0);
        chk("rst.error", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle.busy", busy, 0);

        // A: "++." with op_ready high
        add("++.", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add("++.", 0, 1, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 1, 0, 1, 1, 7, 1, 0, 0);
        add("++.", 0, 1, 0, 2, 1, 1, 1, 0, 0);
        add("++.", 0, 1, 0, 3, 0, 0, 1, 0, 0);
        add("++.", 0, 1, 0, 3, 0, 0, 0, 1, 0);
        // B: same program, executor stalls 5 cycles; a start while running is ignored
        add("++.", 1, 0, 0, 3, 0, 0, 0, 1, 0);
        add("++.", 0, 0, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 0, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 1, 0, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 0, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 0, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 1, 0, 0, 1, 7, 1, 0, 0);
        add("++.", 0, 1, 0, 1, 1, 7, 1, 0, 0);
        add("++.", 0, 1, 0, 2, 1, 1, 1, 0, 0);
        add("++.", 0, 1, 0, 3, 0, 0, 1, 0, 0);
        add("++.", 0, 1, 0, 3, 0, 0, 0, 1, 0);
        // C: nested forward skip with cell_zero=1
        add("[[-]+].", 1, 1, 1, 3, 0, 0, 0, 1, 0);
        add("[[-]+].", 0, 1, 1, 0, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 1, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 2, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 3, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 4, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 5, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 6, 1, 1, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 7, 0, 0, 1, 0, 0);
        add("[[-]+].", 0, 1, 1, 7, 0, 0, 0, 1, 0);
        // D: unmatched ] at address 0, then restart clears error
        add("]+", 1, 1, 0, 7, 0, 0, 0, 1, 0);
        add("]+", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add("]+", 0, 1, 0, 0, 0, 0, 0, 1, 1);
        add("]+", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        add("]+", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add("]+", 0, 1, 0, 0, 0, 0, 0, 1, 1);
        // E: depth overflow (2-bit depth counter) while skipping
        add("[[[[", 1, 1, 1, 0, 0, 0, 0, 1, 1);
        add("[[[[", 0, 1, 1, 0, 0, 0, 1, 0, 0);
        add("[[[[", 0, 1, 1, 1, 0, 0, 1, 0, 0);
        add("[[[[", 0, 1, 1, 2, 0, 0, 1, 0, 0);
        add("[[[[", 0, 1, 1, 3, 0, 0, 1, 0, 0);
        add("[[[[", 0, 1, 1, 3, 0, 0, 0, 1, 1);
        // F: program ends inside a forward skip
        add("[+", 1, 1, 1, 3, 0, 0, 0, 1, 1);
        add("[+", 0, 1, 1, 0, 0, 0, 1, 0, 0);
        add("[+", 0, 1, 1, 1, 0, 0, 1, 0, 0);
        add("[+", 0, 1, 1, 2, 0, 0, 1, 0, 0);
        add("[+", 0, 1, 1, 2, 0, 0, 0, 1, 1);
`ifdef BF_RETURN_STACK_EN
        // H: third push into a 2-entry stack
        add("[[[", 1, 1, 0, 2, 0, 0, 0, 1, 1);
        add("[[[", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add("[[[", 0, 1, 0, 1, 0, 0, 1, 0, 0);
        add("[[[", 0, 1, 0, 2, 0, 0, 1, 0, 0);
        add("[[[", 0, 1, 0, 2, 0, 0, 0, 1, 1);
`else
        // G: backward scan reaches address 0 without a [
        add("+]", 1, 1, 0, 2, 0, 0, 0, 1, 1);
        add("+]", 0, 1, 0, 0, 1, 7, 1, 0, 0);
        add("+]", 0, 1, 0, 1, 0, 0, 1, 0, 0);
        add("+]", 0, 1, 0, 0, 0, 0, 1, 0, 0);
        add("+]", 0, 1, 0, 0, 0, 0, 0, 1, 1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            load_prog(tbl[i].prog);
            start     = tbl[i].start;
            op_ready  = tbl[i].rdy;
            cell_zero = tbl[i].cz;
            #1;
            chk($sformatf("v%0d.addr", i), rom_addr, tbl[i].addr);
            chk($sformatf("v%0d.valid", i), op_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("v%0d.code", i), op_code, tbl[i].code);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d.halted", i), halted, tbl[i].hlt);
            chk($sformatf("v%0d.error", i), error, tbl[i].err);
        end

        // Backward loop "-[-]." : cell becomes zero after the third accepted '-'
        load_prog("-[-].");
        minus_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            start     = (c == 0);
            op_ready  = 1'b1;
            cell_zero = (minus_cnt >= 3);
            #1;
            if (c > 0 && halted) begin
                done = 1'b1;
            end else if (c > 0) begin
                trace.push_back(rom_addr);
                if (op_valid) begin
                    ops.push_back(op_code);
                    if (op_code == 3'b110) minus_cnt++;
                end
            end
        end
        chk("loop.done", done, 1);
        chk("loop.error", error, 0);
`ifdef BF_RETURN_STACK_EN
        exp_trace = '{0, 1, 2, 3, 2, 3, 4, 5};
`else
        exp_trace = '{0, 1, 2, 3, 2, 1, 2, 3, 4, 5};
`endif
        chk("loop.trace_len", trace.size(), exp_trace.size());
        for (int i = 0; i < trace.size() && i < exp_trace.size(); i++) begin
            chk($sformatf("loop.addr%0d", i), trace[i], exp_trace[i]);
        end
        chk("loop.ops_len", ops.size(), 4);
        if (ops.size() == 4) begin
            chk("loop.op0", ops[0], 3'b110);
            chk("loop.op1", ops[1], 3'b110);
            chk("loop.op2", ops[2], 3'b110);
            chk("loop.op3", ops[3], 3'b001);
        end

        // Mid-run reset: returns to reset values, no handshake completes
        load_prog("++.");
        @(negedge clk); start = 1'b1; op_ready = 1'b0; cell_zero = 1'b0;
        @(negedge clk); start = 1'b0; op_ready = 1'b1;
        @(negedge clk); op_ready = 1'b0;
        #1;
        chk("mrst.pre_addr", rom_addr, 1);
        chk("mrst.pre_busy", busy, 1);
        @(negedge clk); rst_n = 1'b0; op_ready = 1'b1;
        #1;
        chk("mrst.addr", rom_addr, 0);
        chk("mrst.valid", op_valid, 0);
        chk("mrst.busy", busy, 0);
        chk("mrst.halted", halted, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("mrst.post_addr", rom_addr, 0);
        chk("mrst.post_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
